// File: rtl/mul_unit_pipe.sv
// Pipelined DATA_W x DATA_W multiply unit with MUL/MULH/MULHU/MULHSU ops.
// Optional MUL_PERF_CNT_EN adds a saturating count of delivered results.
module mul_unit_pipe #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2,
    parameter int PREG_W  = 5,
    parameter int ROB_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze_back,
    input  logic              valid_mul,
    input  logic [1:0]        op_mul,
    input  logic [PREG_W-1:0] Pw_mul,
    input  logic [ROB_W-1:0]  tag_ROB_mul,
    input  logic [DATA_W-1:0] busA_mul,
    input  logic [DATA_W-1:0] busB_mul,
    output logic              valid_Result_mul,
    output logic [PREG_W-1:0] Pw_Result_mul,
    output logic [ROB_W-1:0]  tag_ROB_Result_mul,
    output logic [DATA_W-1:0] Result_mul,
    output logic              busy_mul
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cnt_mul
`endif
);

    localparam int PW = 2 * DATA_W;

    logic              sign_a;
    logic              sign_b;
    logic [PW-1:0]     ext_a;
    logic [PW-1:0]     ext_b;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] sel;

    logic [LATENCY-1:0] v_q;
    logic [PREG_W-1:0]  pw_q  [LATENCY];
    logic [ROB_W-1:0]   tag_q [LATENCY];
    logic [DATA_W-1:0]  res_q [LATENCY];

    // Extending to the full product width makes a plain modular multiply
    // yield the correct signed/unsigned/mixed product.
    always_comb begin
        sign_a = op_mul[0];
        sign_b = (op_mul == 2'b01);
        ext_a  = {{DATA_W{sign_a & busA_mul[DATA_W-1]}}, busA_mul};
        ext_b  = {{DATA_W{sign_b & busB_mul[DATA_W-1]}}, busB_mul};
        prod   = ext_a * ext_b;
        if (op_mul == 2'b00) sel = prod[DATA_W-1:0];
        else                 sel = prod[PW-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pw_q[i]  <= '0;
                tag_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else if (!freeze_back) begin
            v_q[0]   <= valid_mul;
            pw_q[0]  <= Pw_mul;
            tag_q[0] <= tag_ROB_mul;
            res_q[0] <= sel;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i]   <= v_q[i-1];
                pw_q[i]  <= pw_q[i-1];
                tag_q[i] <= tag_q[i-1];
                res_q[i] <= res_q[i-1];
            end
        end
    end

    assign valid_Result_mul   = v_q[LATENCY-1];
    assign Pw_Result_mul      = pw_q[LATENCY-1];
    assign tag_ROB_Result_mul = tag_q[LATENCY-1];
    assign Result_mul         = res_q[LATENCY-1];
    assign busy_mul           = |v_q;

`ifdef MUL_PERF_CNT_EN
    logic load_out;

    if (LATENCY == 1) begin : g_lo1
        assign load_out = valid_mul;
    end else begin : g_lon
        assign load_out = v_q[LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            perf_cnt_mul <= '0;
        end else if (!freeze_back && load_out && perf_cnt_mul != 32'hFFFF_FFFF) begin
            perf_cnt_mul <= perf_cnt_mul + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mul_unit_pipe.md
Name: mul_unit_pipe

Overview:
- Parametrised successor to the fixed two-stage 16-bit multiply execution unit on the integer back end.
- Generic operand width and configurable pipeline latency.
- Adds RISC-style op modes: low product, signed high, unsigned high, signed×unsigned high.
- Adds a busy indication.
- Sits between the multiply issue queue and the writeback/CDB arbiter; obeys the back-end flush and freeze_back controls.

Parameters:
- DATA_W, 16, operand and result width in bits (≥2).
- LATENCY, 2, cycles from input sample to valid result register (≥1).
- PREG_W, 5, physical destination register tag width.
- ROB_W, 5, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all in-flight ops.
- freeze_back  in  1  back-end stall; hold all state.
- valid_mul  in  1  issue valid.
- op_mul  in  2  00 MUL low, 01 MULH s×s, 10 MULHU u×u, 11 MULHSU s(A)×u(B).
- Pw_mul  in  PREG_W  destination physical register.
- tag_ROB_mul  in  ROB_W  ROB tag.
- busA_mul  in  DATA_W  operand A.
- busB_mul  in  DATA_W  operand B.
- valid_Result_mul  out  1  result valid.
- Pw_Result_mul  out  PREG_W  destination of result.
- tag_ROB_Result_mul  out  ROB_W  ROB tag of result.
- Result_mul  out  DATA_W  selected product half.
- busy_mul  out  1  any pipeline stage or output register holds a valid op.

Behaviour:
- Pipeline: LATENCY register stages, each holding {valid, op, Pw, tag, data}. The final stage is the output register set. Internal split of the multiply across stages is implementation choice. Result must equal the spec below exactly LATENCY cycles after sampling.
- Arithmetic: form the full 2·DATA_W product.
  - Op 00: low DATA_W bits; signedness irrelevant.
  - Op 01: both operands sign-extended; high DATA_W bits.
  - Op 10: both zero-extended; high DATA_W bits.
  - Op 11: A sign-extended, B zero-extended; high DATA_W bits.
- Sampling: inputs are sampled on every edge where rst=0, flush=0 and freeze_back=0. valid_mul=0 inserts a bubble (valid=0 advances). There is no ready output; the issuer must not issue while freeze_back=1. Inputs presented during freeze are ignored and lost.
- Advance: when not frozen and not flushed, every stage shifts one step per cycle; a new op may enter every cycle (throughput 1/cycle).
- freeze_back=1: all stage registers and outputs hold their values, including valid_Result_mul. A held valid result stays asserted for the whole freeze.
- Flush: flush=1 clears every valid bit, including valid_Result_mul, on the next edge. Flush has priority over freeze_back. Inputs sampled in the same cycle as flush are discarded. Payload fields may clear to 0 or hold; outputs are checked only when valid.
- rst=1: on the next edge all valid bits and all outputs go to 0 (valid_Result_mul=0, Pw_Result_mul=0, tag_ROB_Result_mul=0, Result_mul=0). rst has priority over flush and freeze. Reset mid-operation drops all ops.
- busy_mul: combinational OR of all stage valid bits including valid_Result_mul. It is 0 after reset and after flush.
- LATENCY=1: the output register is the only stage; product and selection are computed combinationally from the inputs.

Optional Feature:
- Macro MUL_PERF_CNT_EN.
- Defined: adds output perf_cnt_mul (out, 32) and internal counter.
  - Reset and flush clear it to 0.
  - Increments by 1 on each edge that loads a valid op into the output register (not frozen, not flushed).
  - Saturates at 0xFFFFFFFF.
  - A result held across freeze is counted once.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DATA_W=16, LATENCY=2: issue A=3, B=5, op 00, Pw=7, tag=9 at cycle t → at t+2 valid_Result_mul=1, Result_mul=0x000F, Pw=7, tag=9; at t+3 valid=0.
- A=B=0xFFFF issued back-to-back with ops 00, 01, 10, 11 → consecutive results 0x0001, 0x0000, 0xFFFE, 0xFFFF.
- A=0x8000, B=0x8000, op 01 → 0x4000. A=0x8000, B=0x0002, op 11 → 0xFFFF. Same operands, op 10 → 0x0001.
- Issue ops X, Y at t, t+1; freeze_back=1 at t+2 for 3 cycles → X result held valid for 4 cycles total; Y appears exactly one cycle after freeze drops; no duplicate, no loss.
- Issue at t, t+1, flush=1 at t+1 → no valid_Result_mul at t+2 or t+3; busy_mul=0 at t+2. Flush and freeze both high → flush wins.
- Issue at t, rst=1 at t+1 → all outputs 0 at t+2, busy_mul=0, and perf_cnt_mul=0 when MUL_PERF_CNT_EN is defined. Sweep LATENCY=1 and LATENCY=4 with 1000 random ops against a reference model: all results match.
